dmem_mmio_responder: RTL

DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

---
 rtl/dmem_mmio_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dmem_mmio_responder.sv
// Processor data-memory responder: 4096-word RAM plus a small MMIO window
// (output FIFO, FIFO status, optional cycle counter under DMEM_CYCLE_COUNTER_EN).
module dmem_mmio_responder (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam logic [31:0] ADDR_OUT_DATA   = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_OUT_STATUS = 32'hFFFF_0001;
    localparam logic [31:0] ADDR_CYCLE      = 32'hFFFF_0002;
    localparam int          FIFO_DEPTH      = 8;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic ram_hit;
    logic hit_out_data;
    logic hit_out_status;

    assign ram_hit        = (address_dmem[31:12] == 20'd0);
    assign hit_out_data   = (address_dmem == ADDR_OUT_DATA);
    assign hit_out_status = (address_dmem == ADDR_OUT_STATUS);

    // ------------------------------------------------------------------
    // RAM: no reset so contents survive reset; read-before-write
    // ------------------------------------------------------------------
    logic [31:0] ram_mem [0:4095];
    logic [31:0] ram_q_reg;

    always_ff @(posedge clock) begin
        if (wren && ram_hit) begin
            ram_mem[address_dmem[11:0]] <= data;
        end
        ram_q_reg <= ram_mem[address_dmem[11:0]];
    end

    // ------------------------------------------------------------------
    // Output FIFO control
    // ------------------------------------------------------------------
    logic [2:0]  wr_ptr_reg;
    logic [2:0]  rd_ptr_reg;
    logic [3:0]  fifo_count_reg;
    logic [3:0]  fifo_count_next;
    logic        overflow_reg;
    logic        overflow_next;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_req;
    logic        push_en;
    logic        pop_en;

    assign fifo_full  = (fifo_count_reg == 4'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count_reg == 4'd0);
    assign push_req   = wren && hit_out_data;
    assign pop_en     = !fifo_empty && out_ready;
    // A pop on the same edge frees the slot, so a push while full still lands.
    assign push_en    = push_req && (!fifo_full || pop_en);

    always_comb begin
        fifo_count_next = fifo_count_reg;
        case ({push_en, pop_en})
            2'b10:   fifo_count_next = fifo_count_reg + 4'd1;
            2'b01:   fifo_count_next = fifo_count_reg - 4'd1;
            default: fifo_count_next = fifo_count_reg;
        endcase
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (wren && hit_out_status) begin
            overflow_next = 1'b0;
        end else if (push_req && fifo_full && !pop_en) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= 3'd0;
            rd_ptr_reg     <= 3'd0;
            fifo_count_reg <= 4'd0;
            overflow_reg   <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 3'd1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 3'd1;
            end
            fifo_count_reg <= fifo_count_next;
            overflow_reg   <= overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: one register per slot; validity is tracked by count
    // ------------------------------------------------------------------
    logic [31:0] entry_data [0:FIFO_DEPTH-1];

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gen_entry
            logic [31:0] entry_reg;

            always_ff @(posedge clock) begin
                if (push_en && (wr_ptr_reg == 3'(gi))) begin
                    entry_reg <= data;
                end
            end

            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 32'd0 : entry_data[rd_ptr_reg];

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_reg;
    logic        hit_cycle;

    assign hit_cycle = (address_dmem == ADDR_CYCLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_reg <= 32'd0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // MMIO read mux and registered read path
    // ------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] mmio_rdata;
    logic [31:0] mmio_q_reg;
    logic        sel_ram_reg;

    assign status_word = {25'd0, overflow_reg, fifo_empty, fifo_full, fifo_count_reg};

    always_comb begin
        mmio_rdata = 32'd0;
        if (hit_out_status) begin
            mmio_rdata = status_word;
        end
`ifdef DMEM_CYCLE_COUNTER_EN
        if (hit_cycle) begin
            mmio_rdata = cycle_reg;
        end
`endif
    end

    // Reset clears the source select too, so an in-flight RAM read reads as 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_ram_reg <= 1'b0;
            mmio_q_reg  <= 32'd0;
        end else begin
            sel_ram_reg <= ram_hit;
            mmio_q_reg  <= mmio_rdata;
        end
    end

    assign q_dmem = sel_ram_reg ? ram_q_reg : mmio_q_reg;

endmodule
